// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared divider defines used by the EX stage and the divider
package div_pkg;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef logic [63:0] DoubleRegBus;

endpackage

// File: rtl/div_if.sv
// rtl/div_if.sv - EX-to-divider request/result bundle
interface div_if #(parameter int DATA_W = 32);

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div.sv
// rtl/div.sv - multicycle restoring divider, one quotient bit per clock
// result_o = {remainder, quotient}; signed mode divides magnitudes then fixes signs.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  localparam int              CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W:0]   r_work;
  logic [DATA_W-1:0]   r_opd2;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic                w_sign1;
  logic                w_sign2;
  logic [DATA_W-1:0]   w_mag1;
  logic [DATA_W-1:0]   w_mag2;
  logic [2*DATA_W:0]   w_shift;
  logic [DATA_W:0]     w_diff;
  logic [2*DATA_W:0]   w_step;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;

  always_comb begin
    w_sign1 = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    w_sign2 = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    w_mag1  = w_sign1 ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    w_mag2  = w_sign2 ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
  end

  // The remainder field is always below the divisor, so the shifted value
  // fits in DATA_W+1 bits and the difference MSB is the borrow.
  always_comb begin
    w_shift = {r_work[2*DATA_W-1:0], 1'b0};
    w_diff  = w_shift[2*DATA_W:DATA_W] - {1'b0, r_opd2};
    if (!w_diff[DATA_W]) begin
      w_step = {w_diff, w_shift[DATA_W-1:1], 1'b1};
    end else begin
      w_step = w_shift;
    end
    w_quo_fix = r_neg_q ? (~w_step[DATA_W-1:0] + 1'b1) : w_step[DATA_W-1:0];
    w_rem_fix = r_neg_r ? (~w_step[2*DATA_W-1:DATA_W] + 1'b1)
                        : w_step[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      r_work   <= '0;
      r_opd2   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          r_result <= '0;
          r_ready  <= DivResultNotReady;
          if (bus.start_i == DivStart && !bus.annul_i) begin
            r_opd2  <= w_mag2;
            r_neg_q <= w_sign1 ^ w_sign2;
            r_neg_r <= w_sign1;
            r_work  <= {{(DATA_W+1){1'b0}}, w_mag1};
            r_cnt   <= '0;
            r_state <= (bus.opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          if (bus.annul_i) begin
            r_state <= DivFree;
          end else begin
            r_result <= '0;
            r_ready  <= DivResultReady;
            r_state  <= DivEnd;
          end
        end
        DivOn: begin
          if (bus.annul_i) begin
            r_state  <= DivFree;
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= DivResultNotReady;
          end else begin
            r_work <= w_step;
            if (r_cnt == CNT_LAST) begin
              r_result <= {w_rem_fix, w_quo_fix};
              r_ready  <= DivResultReady;
              r_cnt    <= '0;
              r_state  <= DivEnd;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        DivEnd: begin
          if (bus.start_i == DivStop) begin
            r_result <= '0;
            r_ready  <= DivResultNotReady;
            r_state  <= DivFree;
          end
        end
        default: r_state <= DivFree;
      endcase
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed self-checking bench for the divider
module tb_div;
  import div_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_if #(.DATA_W(32)) bus ();

  div #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Operands are scrambled after acceptance to show they were latched.
  task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input DoubleRegBus exp, input int exp_lat);
    int n;
    bus.signed_div_i = sg;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    tick();
    n = 1;
    bus.opdata1_i    = ~a;
    bus.opdata2_i    = b ^ 32'h0000_0005;
    bus.signed_div_i = ~sg;
    while (bus.ready_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, bus.result_o, exp);
    tick();
    check({tag, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
    check({tag, "_hold_result"}, bus.result_o, exp);
    bus.start_i = 1'b0;
    tick();
    check({tag, "_free_ready"}, 64'(bus.ready_o), 64'd0);
    check({tag, "_free_result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    int n;
    logic seen_ready;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = ZeroWord;
    bus.opdata2_i    = ZeroWord;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #1;
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    tick();
    tick();
    rst = 1'b0;

    do_div("s_7_2",      1'b1, 32'd7,          32'd2,          64'h00000001_00000003, 33);
    do_div("s_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 33);
    do_div("u_ffff_16",  1'b0, 32'hFFFF_FFFF,  32'h0000_0010,  64'h0000000F_0FFFFFFF, 33);
    do_div("s_m1_16",    1'b1, 32'hFFFF_FFFF,  32'h0000_0010,  64'hFFFFFFFF_00000000, 33);
    do_div("div_zero",   1'b1, 32'd1234,       32'd0,          64'h0,                 2);

    // annul at iteration 10
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    tick();
    seen_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ready_o !== 1'b0) seen_ready = 1'b1;
    end
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    bus.annul_i = 1'b0;
    check("annul_no_ready", 64'(seen_ready | bus.ready_o), 64'd0);
    check("annul_state_free", 64'(dut.r_state), 64'(DivFree));
    check("annul_result", bus.result_o, 64'd0);
    do_div("u_100_7",    1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33);

    // reset while holding a result in END clears outputs without a clock edge
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'd7;
    bus.opdata2_i    = 32'd2;
    bus.start_i      = 1'b1;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("end_ready_before_rst", 64'(bus.ready_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_end_ready", 64'(bus.ready_o), 64'd0);
    check("rst_end_result", bus.result_o, 64'd0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    tick();

    // reset mid-ON
    bus.opdata1_i = 32'd12345;
    bus.opdata2_i = 32'd17;
    bus.start_i   = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_on_state", 64'(dut.r_state), 64'(DivFree));
    check("rst_on_cnt_zero", 64'(dut.r_cnt == '0), 64'd1);
    check("rst_on_work_zero", 64'(dut.r_work == '0), 64'd1);
    check("rst_on_ready", 64'(bus.ready_o), 64'd0);
    check("rst_on_result", bus.result_o, 64'd0);
    rst = 1'b0;
    do_div("s_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 32, operand width; the iteration count SHALL equal DATA_W.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 The block SHALL have port signed_div_i, input, 1, 1 = two's-complement divide, 0 = unsigned divide.
REQ-005 The block SHALL have port opdata1_i, input, DATA_W, dividend.
REQ-006 The block SHALL have port opdata2_i, input, DATA_W, divisor.
REQ-007 The block SHALL have port start_i, input, 1, request from EX; it is held high until ready_o is seen.
REQ-008 The block SHALL have port annul_i, input, 1, abort of the in-flight divide (pipeline flush).
REQ-009 The block SHALL have port result_o, output, 2*DATA_W, {remainder, quotient}; EX writes the upper half to HI and the lower half to LO.
REQ-010 The block SHALL have port ready_o, output, 1, result valid (DivResultReady).

Function
REQ-011 The block SHALL implement a 2-bit FSM with states FREE, BYZERO, ON and END, and SHALL drive result_o and ready_o from registers.
REQ-012 FREE: on an edge with start_i=1 and annul_i=0, the block SHALL latch the operands and signed_div_i; it SHALL go to BYZERO if opdata2_i==0, otherwise to ON with cnt=0.
REQ-013 FREE latch, signed mode: each operand with MSB=1 SHALL be stored as its two's-complement magnitude; unsigned operands SHALL be stored unchanged.
REQ-014 ON: each edge SHALL perform one restoring step on a (2*DATA_W+1)-bit working register {rem, quo}.
- Shift the register left by 1.
- Trial-subtract the divisor from the upper DATA_W+1 bits.
- If the difference is non-negative, write it back and set the quotient LSB to 1.
REQ-015 ON lasts exactly DATA_W edges; on the DATA_W-th edge the block SHALL apply sign correction, load result_o, set ready_o=1 and go to END.
REQ-016 Sign correction, signed mode only:
- Quotient negated when the operand signs differ.
- Remainder negated when the dividend was negative.
REQ-017 Overflow case 0x80000000 / 0xFFFFFFFF (signed) SHALL yield quotient 0x80000000 and remainder 0, with no trap.
REQ-018 BYZERO: the next edge SHALL go to END with result_o=0 and ready_o=1.
REQ-019 END: the block SHALL hold result_o and ready_o while start_i=1; on an edge with start_i=0 it SHALL go to FREE with result_o=0 and ready_o=0.
REQ-020 annul_i=1 in ON or BYZERO SHALL force FREE on the next edge, with ready_o=0 and result_o=0; annul_i SHALL take priority over iteration and completion.
REQ-021 Changes to start_i or to the operands during ON SHALL be ignored, since the operands are latched at acceptance.
REQ-022 Latency: ready_o SHALL rise after the DATA_W+1-th edge counting the accepting edge (33 for DATA_W=32); for divide-by-zero it SHALL rise after the 2nd edge.
REQ-023 A new request SHALL be accepted no earlier than the edge after END→FREE; ready_o SHALL be 0 in FREE, BYZERO and ON.

Reset
REQ-024 rst=1 SHALL asynchronously force state=FREE, cnt=0, working register=0, result_o=0 and ready_o=0, including mid-ON.
REQ-025 After rst deasserts, the block SHALL accept a request on the first edge with start_i=1.

Structure
REQ-026 The shared defines package SHALL hold the following, used by both ex and div:
- State encodings DivFree, DivByZero, DivOn, DivEnd.
- DivResultReady and DivResultNotReady.
- DivStart and DivStop.
- ZeroWord and DoubleRegBus.
REQ-027 No sub-module SHALL be used; the trial subtractor and the magnitude/negate logic SHALL be inline. Synthesis SHALL infer a single DATA_W+1-bit subtractor.

Verification
REQ-028 Signed 7 / 2: the bench SHALL check result_o=0x00000001_00000003, with ready_o rising 33 edges after acceptance.
REQ-029 Signed -7 (0xFFFFFFF9) / 2: the bench SHALL check result_o=0xFFFFFFFF_FFFFFFFD (remainder -1, quotient -3).
REQ-030 Unsigned 0xFFFFFFFF / 0x10: the bench SHALL check result_o=0x0000000F_0FFFFFFF; the same operands in signed mode SHALL give 0xFFFFFFFF_00000000.
REQ-031 Divisor 0: the bench SHALL check ready_o=1 after 2 edges with result_o=0; dropping start_i SHALL return the FSM to FREE and clear ready_o.
REQ-032 annul_i pulsed at iteration 10: the bench SHALL check FREE on the next edge with ready_o never asserted; a new 100/7 request (unsigned) SHALL then complete with result_o=0x00000002_0000000E.
REQ-033 rst asserted mid-ON: the bench SHALL check that outputs clear immediately without waiting for a clock edge, and that signed 0x80000000 / 0xFFFFFFFF afterwards gives result_o=0x00000000_80000000.
